// File: rtl/yin_pitch_tracker.sv
// Streaming YIN pitch estimator: ring-buffered samples, incremental difference function,
// CMNDF test by cross-multiplication, local-minimum refinement and serial lag-to-Hz divide.
module yin_pitch_tracker #(
  parameter int unsigned SIG_WIDTH   = 12,
  parameter int unsigned WINDOW_SIZE = 500,
  parameter int unsigned TAU_MIN     = 8,
  parameter int unsigned TAU_MAX     = 100,
  parameter int unsigned SAMPLE_RATE = 8000,
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned FRAC_BITS   = 16
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic signed [SIG_WIDTH-1:0]  sig_in,
  input  logic                         sig_in_valid,
  input  logic                         start_in,
  input  logic [15:0]                  threshold_in,
  output logic                         busy_out,
  output logic [WIDTH-1:0]             f_out,
  output logic [$clog2(TAU_MAX+1)-1:0] tau_out,
  output logic                         voiced_out,
  output logic                         f_out_valid,
  output logic                         drop_out
);

  localparam int unsigned TAU_W  = $clog2(TAU_MAX + 1);
  localparam int unsigned WIN_W  = WINDOW_SIZE - TAU_MAX;
  localparam int unsigned PTR_W  = $clog2(WINDOW_SIZE);
  localparam int unsigned IDX_W  = PTR_W + 1;
  localparam int unsigned FILL_W = $clog2(WINDOW_SIZE + 1);
  localparam int unsigned J_W    = $clog2(WIN_W);
  localparam int unsigned DIFF_W = SIG_WIDTH + 1;
  localparam int unsigned SQ_W   = 2 * DIFF_W;
  localparam int unsigned ACC_W  = 2 * SIG_WIDTH + 2 + $clog2(WIN_W);
  localparam int unsigned S_W    = ACC_W + $clog2(TAU_MAX);
  localparam int unsigned LP_W   = ACC_W + TAU_W;
  localparam int unsigned RP_W   = S_W + 16;
  localparam int unsigned CMP_W  = (LP_W + 16 > RP_W) ? LP_W + 16 : RP_W;
  localparam int unsigned REM_W  = TAU_W + 1;
  localparam int unsigned DCNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] DIVIDEND = WIDTH'(SAMPLE_RATE) << FRAC_BITS;

  typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_TEST, S_DIVIDE, S_DONE} state_t;

  state_t state_q, state_d;

  logic signed [SIG_WIDTH-1:0] sample_mem [WINDOW_SIZE];

  logic [PTR_W-1:0]  wr_ptr_q, base_q;
  logic [FILL_W-1:0] fill_q;
  logic [TAU_W-1:0]  tau_q, cand_q;
  logic [J_W-1:0]    j_q;
  logic [ACC_W-1:0]  acc_q, dmin_q;
  logic [S_W-1:0]    s_q;
  logic [15:0]       thr_q;
  logic              hit_q;
  logic [WIDTH-1:0]  quo_q;
  logic [REM_W-1:0]  rem_q;
  logic [DCNT_W-1:0] dcnt_q;

  logic [PTR_W-1:0]         wr_ptr_nxt_c, idx_a_c, idx_b_c;
  logic [FILL_W-1:0]        fill_nxt_c;
  logic                     full_at_start_c;
  logic [IDX_W-1:0]         sum_a_c, sum_b_c;
  logic signed [DIFF_W-1:0] diff_c;
  logic signed [SQ_W-1:0]   diff_ext_c, sq_c;
  logic [S_W-1:0]           s_new_c;
  logic [LP_W-1:0]          dtau_c;
  logic [RP_W-1:0]          ts_c;
  logic [CMP_W-1:0]         lhs_c, rhs_c;
  logic                     cond_c, better_c, cand_upd_c;
  logic                     j_last_c, tau_last_c, dcnt_last_c;
  logic [REM_W-1:0]         rem_sh_c, cand_ext_c;
  logic                     ge_c;

  // Write pointer / fill bookkeeping for the sample arriving this cycle
  always_comb begin
    wr_ptr_nxt_c    = (wr_ptr_q == PTR_W'(WINDOW_SIZE - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    fill_nxt_c      = (fill_q == FILL_W'(WINDOW_SIZE)) ? fill_q : fill_q + FILL_W'(1);
    full_at_start_c = sig_in_valid ? (fill_nxt_c == FILL_W'(WINDOW_SIZE))
                                   : (fill_q == FILL_W'(WINDOW_SIZE));
  end

  // x[j] and x[j+tau] relative to the oldest sample; sums stay below 2*WINDOW_SIZE
  always_comb begin
    sum_a_c    = IDX_W'(base_q) + IDX_W'(j_q);
    sum_b_c    = sum_a_c + IDX_W'(tau_q);
    idx_a_c    = PTR_W'((sum_a_c >= IDX_W'(WINDOW_SIZE)) ? sum_a_c - IDX_W'(WINDOW_SIZE) : sum_a_c);
    idx_b_c    = PTR_W'((sum_b_c >= IDX_W'(WINDOW_SIZE)) ? sum_b_c - IDX_W'(WINDOW_SIZE) : sum_b_c);
    diff_c     = DIFF_W'(sample_mem[idx_a_c]) - DIFF_W'(sample_mem[idx_b_c]);
    diff_ext_c = SQ_W'(diff_c);
    sq_c       = diff_ext_c * diff_ext_c;
  end

  // CMNDF below threshold: (d*tau) << 16 < thr * S, S including the current lag
  always_comb begin
    s_new_c     = s_q + S_W'(acc_q);
    dtau_c      = LP_W'(acc_q) * LP_W'(tau_q);
    ts_c        = RP_W'(thr_q) * RP_W'(s_new_c);
    lhs_c       = CMP_W'(dtau_c) << 16;
    rhs_c       = CMP_W'(ts_c);
    cond_c      = (tau_q >= TAU_W'(TAU_MIN)) && (s_new_c != '0) && (lhs_c < rhs_c);
    better_c    = acc_q < dmin_q;
    cand_upd_c  = hit_q ? better_c : cond_c;
    j_last_c    = (j_q == J_W'(WIN_W - 1));
    tau_last_c  = (tau_q == TAU_W'(TAU_MAX));
    dcnt_last_c = (dcnt_q == DCNT_W'(WIDTH - 1));
  end

  // Restoring divider step
  always_comb begin
    rem_sh_c   = {rem_q[REM_W-2:0], quo_q[WIDTH-1]};
    cand_ext_c = REM_W'(cand_q);
    ge_c       = rem_sh_c >= cand_ext_c;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_in) state_d = full_at_start_c ? S_ACCUM : S_DONE;
      S_ACCUM:  if (j_last_c) state_d = S_TEST;
      S_TEST: begin
        if (!hit_q) begin
          if (tau_last_c) state_d = cond_c ? S_DIVIDE : S_DONE;
          else            state_d = S_ACCUM;
        end else if (better_c && !tau_last_c) begin
          state_d = S_ACCUM;
        end else begin
          state_d = S_DIVIDE;
        end
      end
      S_DIVIDE: if (dcnt_last_c) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in && state_q == S_IDLE && sig_in_valid) sample_mem[wr_ptr_q] <= sig_in;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr_q    <= '0;
      base_q      <= '0;
      fill_q      <= '0;
      tau_q       <= '0;
      cand_q      <= '0;
      j_q         <= '0;
      acc_q       <= '0;
      dmin_q      <= '0;
      s_q         <= '0;
      thr_q       <= '0;
      hit_q       <= 1'b0;
      quo_q       <= '0;
      rem_q       <= '0;
      dcnt_q      <= '0;
      busy_out    <= 1'b0;
      f_out       <= '0;
      tau_out     <= '0;
      voiced_out  <= 1'b0;
      f_out_valid <= 1'b0;
      drop_out    <= 1'b0;
    end else begin
      f_out_valid <= 1'b0;
      drop_out    <= sig_in_valid && (state_q != S_IDLE);
      busy_out    <= (state_d != S_IDLE);
      case (state_q)
        S_IDLE: begin
          if (sig_in_valid) begin
            wr_ptr_q <= wr_ptr_nxt_c;
            fill_q   <= fill_nxt_c;
          end
          if (start_in) begin
            thr_q  <= threshold_in;
            base_q <= sig_in_valid ? wr_ptr_nxt_c : wr_ptr_q;
            tau_q  <= TAU_W'(1);
            j_q    <= '0;
            acc_q  <= '0;
            s_q    <= '0;
            hit_q  <= 1'b0;
          end
        end
        S_ACCUM: begin
          acc_q <= acc_q + ACC_W'($unsigned(sq_c));
          j_q   <= j_last_c ? '0 : j_q + J_W'(1);
        end
        S_TEST: begin
          acc_q <= '0;
          s_q   <= s_new_c;
          if (cand_upd_c) begin
            cand_q <= tau_q;
            dmin_q <= acc_q;
          end
          if (cond_c) hit_q <= 1'b1;
          if (state_d == S_ACCUM) tau_q <= tau_q + TAU_W'(1);
          quo_q  <= DIVIDEND;
          rem_q  <= '0;
          dcnt_q <= '0;
        end
        S_DIVIDE: begin
          rem_q  <= ge_c ? rem_sh_c - cand_ext_c : rem_sh_c;
          quo_q  <= {quo_q[WIDTH-2:0], ge_c};
          dcnt_q <= dcnt_q + DCNT_W'(1);
        end
        S_DONE: begin
          f_out       <= hit_q ? quo_q : '0;
          tau_out     <= hit_q ? cand_q : '0;
          voiced_out  <= hit_q;
          f_out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_yin_pitch_tracker.sv
// Directed bench for yin_pitch_tracker: table of fill/start runs plus drop and mid-run reset sequences.
module tb_yin_pitch_tracker;

  localparam int unsigned SIG_WIDTH = 12;
  localparam int unsigned TAU_W     = 7;
  localparam int          BOUND     = 60000;

  logic                        clk_in = 1'b0;
  logic                        rst_in;
  logic signed [SIG_WIDTH-1:0] sig_in;
  logic                        sig_in_valid;
  logic                        start_in;
  logic [15:0]                 threshold_in;
  logic                        busy_out;
  logic [31:0]                 f_out;
  logic [TAU_W-1:0]            tau_out;
  logic                        voiced_out;
  logic                        f_out_valid;
  logic                        drop_out;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_in = ~clk_in;

  yin_pitch_tracker dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .sig_in       (sig_in),
    .sig_in_valid (sig_in_valid),
    .start_in     (start_in),
    .threshold_in (threshold_in),
    .busy_out     (busy_out),
    .f_out        (f_out),
    .tau_out      (tau_out),
    .voiced_out   (voiced_out),
    .f_out_valid  (f_out_valid),
    .drop_out     (drop_out)
  );

  typedef struct {
    int          kind;    // 0 DC 500, 1 sawtooth period 40, 2 sine period 5
    int          count;
    logic [15:0] thr;
    int          exp_lat; // edges from start acceptance to f_out_valid
    logic [6:0]  exp_tau;
    logic        exp_voiced;
    logic [31:0] exp_f;
  } vec_t;

  vec_t vecs [4];

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic signed [SIG_WIDTH-1:0] sample_of(input int kind, input int n);
    int v;
    case (kind)
      0: v = 500;
      1: v = -1000 + 50 * (n % 40);
      default: begin
        case (n % 5)
          0: v = 0;
          1: v = 951;
          2: v = 588;
          3: v = -588;
          default: v = -951;
        endcase
      end
    endcase
    return SIG_WIDTH'(v);
  endfunction

  task automatic fill(input int kind, input int count);
    for (int i = 0; i < count; i++) begin
      sig_in       = sample_of(kind, i);
      sig_in_valid = 1'b1;
      tick();
    end
    sig_in_valid = 1'b0;
  endtask

  // Issue a start and wait (bounded) for the result strobe; lat = -1 on timeout
  task automatic do_run(input logic [15:0] thr, output int lat);
    lat          = -1;
    threshold_in = thr;
    start_in     = 1'b1;
    tick();
    start_in = 1'b0;
    check("busy_after_start", 64'(busy_out), 64'd1);
    for (int k = 1; k <= BOUND; k++) begin
      tick();
      if (f_out_valid) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) $display("FAIL run_timeout: got no f_out_valid within %0d cycles", BOUND);
  endtask

  initial begin
    int lat;
    int n_inj;
    int n_drop;
    int n_res;

    vecs[0] = '{kind: 1, count: 200, thr: 16'h1999, exp_lat: 1,     exp_tau: 7'd0,  exp_voiced: 1'b0, exp_f: 32'h0};
    vecs[1] = '{kind: 0, count: 500, thr: 16'h1999, exp_lat: 40101, exp_tau: 7'd0,  exp_voiced: 1'b0, exp_f: 32'h0};
    vecs[2] = '{kind: 1, count: 500, thr: 16'h1999, exp_lat: 16474, exp_tau: 7'd40, exp_voiced: 1'b1, exp_f: 32'h00C8_0000};
    vecs[3] = '{kind: 2, count: 500, thr: 16'h1999, exp_lat: 4444,  exp_tau: 7'd10, exp_voiced: 1'b1, exp_f: 32'h0320_0000};

    rst_in       = 1'b1;
    sig_in       = '0;
    sig_in_valid = 1'b0;
    start_in     = 1'b0;
    threshold_in = '0;
    repeat (3) tick();
    rst_in = 1'b0;
    check("rst_busy",   64'(busy_out),    64'd0);
    check("rst_f",      64'(f_out),       64'd0);
    check("rst_tau",    64'(tau_out),     64'd0);
    check("rst_voiced", 64'(voiced_out),  64'd0);
    check("rst_valid",  64'(f_out_valid), 64'd0);
    check("rst_drop",   64'(drop_out),    64'd0);

    for (int i = 0; i < 4; i++) begin
      fill(vecs[i].kind, vecs[i].count);
      if (i > 0) check("hold_tau", 64'(tau_out), 64'(vecs[i-1].exp_tau));
      do_run(vecs[i].thr, lat);
      check("latency", 64'(lat),        64'(vecs[i].exp_lat));
      check("tau",     64'(tau_out),    64'(vecs[i].exp_tau));
      check("voiced",  64'(voiced_out), 64'(vecs[i].exp_voiced));
      check("f",       64'(f_out),      64'(vecs[i].exp_f));
      check("busy_at_valid", 64'(busy_out), 64'd0);
      tick();
      check("valid_one_cycle", 64'(f_out_valid), 64'd0);
    end

    // Samples and a second start while busy: all dropped/ignored, result unchanged
    n_inj  = 0;
    n_drop = 0;
    lat    = -1;
    threshold_in = 16'h1999;
    start_in     = 1'b1;
    tick();
    start_in = 1'b0;
    for (int k = 1; k <= BOUND; k++) begin
      if (k % 10 == 0) begin
        sig_in       = 12'sh7FF;
        sig_in_valid = 1'b1;
      end
      if (k == 2000) begin
        start_in     = 1'b1;
        threshold_in = 16'hFFFF;
      end
      tick();
      if (sig_in_valid) begin
        n_inj++;
        if (drop_out) n_drop++;
      end
      sig_in_valid = 1'b0;
      start_in     = 1'b0;
      if (f_out_valid) begin
        lat = k;
        break;
      end
    end
    check("drop_count", 64'(n_drop), 64'(n_inj));
    check("drop_lat",   64'(lat),    64'd4444);
    check("drop_tau",   64'(tau_out), 64'd10);
    check("drop_f",     64'(f_out),   64'h0320_0000);
    n_res = 0;
    repeat (300) begin
      tick();
      if (f_out_valid) n_res++;
    end
    check("no_second_result", 64'(n_res), 64'd0);

    // Reset in the middle of ACCUM aborts silently
    threshold_in = 16'h1999;
    start_in     = 1'b1;
    tick();
    start_in = 1'b0;
    repeat (1000) tick();
    check("busy_mid_run", 64'(busy_out), 64'd1);
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    check("abort_busy",   64'(busy_out),    64'd0);
    check("abort_f",      64'(f_out),       64'd0);
    check("abort_tau",    64'(tau_out),     64'd0);
    check("abort_voiced", 64'(voiced_out),  64'd0);
    check("abort_valid",  64'(f_out_valid), 64'd0);
    n_res = 0;
    repeat (500) begin
      tick();
      if (f_out_valid) n_res++;
    end
    check("abort_no_result", 64'(n_res), 64'd0);

    fill(2, 500);
    check("fresh_hold_tau", 64'(tau_out), 64'd0);
    do_run(16'h1999, lat);
    check("fresh_lat",    64'(lat),        64'd4444);
    check("fresh_tau",    64'(tau_out),    64'd10);
    check("fresh_voiced", 64'(voiced_out), 64'd1);
    check("fresh_f",      64'(f_out),      64'h0320_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
